// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with IF/ID pipeline register and debug counters
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             PC_stall_i,
    input  logic             IFID_stall_i,
    input  logic             Branch_i,
    input  logic [31:0]      BranchAddr_i,
    input  logic             Jump_i,
    input  logic [31:0]      JumpAddr_i,
    input  logic [31:0]      Instr_i,
    output logic [31:0]      InstrAddr_o,
    output logic [31:0]      IFID_PC_o,
    output logic [31:0]      IFID_Instr_o,
    output logic             IFID_Valid_o,
    output logic [CNT_W-1:0] StallCnt_o,
    output logic [CNT_W-1:0] FlushCnt_o
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_pc_q, ifid_pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic             ifid_valid_q, ifid_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             redirect;
    logic [31:0]      target;
    logic [31:0]      pc_plus4;

    // Redirect target selection; an ID instruction that is itself stalled cannot redirect
    always_comb begin
        redirect = (Jump_i | Branch_i) & ~IFID_stall_i;
        target   = Jump_i ? JumpAddr_i : BranchAddr_i;
        target[1:0] = 2'b00;
        pc_plus4 = pc_q + 32'd4;
    end

    // Next-state: redirect beats IF/ID stall beats PC stall beats sequential fetch
    always_comb begin
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        if (!start_i) begin
            ifid_pc_d    = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
        end else if (redirect) begin
            pc_d         = target;
            ifid_pc_d    = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
            if (flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else if (IFID_stall_i) begin
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else if (PC_stall_i) begin
            // Same address is refetched next cycle, so ID sees a bubble now
            ifid_pc_d    = 32'h0;
            ifid_instr_d = 32'h0;
            ifid_valid_d = 1'b0;
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            pc_d         = pc_plus4;
            ifid_pc_d    = pc_plus4;
            ifid_instr_d = Instr_i;
            ifid_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous reset discarding everything in flight
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign InstrAddr_o  = pc_q;
    assign IFID_PC_o    = ifid_pc_q;
    assign IFID_Instr_o = ifid_instr_q;
    assign IFID_Valid_o = ifid_valid_q;
    assign StallCnt_o   = stall_cnt_q;
    assign FlushCnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk_i;
    logic        rst_n_i;
    logic        start_i;
    logic        PC_stall_i;
    logic        IFID_stall_i;
    logic        Branch_i;
    logic [31:0] BranchAddr_i;
    logic        Jump_i;
    logic [31:0] JumpAddr_i;
    logic [31:0] Instr_i;
    logic [31:0] InstrAddr_o;
    logic [31:0] IFID_PC_o;
    logic [31:0] IFID_Instr_o;
    logic        IFID_Valid_o;
    logic [15:0] StallCnt_o;
    logic [15:0] FlushCnt_o;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(32'h0), .CNT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .start_i      (start_i),
        .PC_stall_i   (PC_stall_i),
        .IFID_stall_i (IFID_stall_i),
        .Branch_i     (Branch_i),
        .BranchAddr_i (BranchAddr_i),
        .Jump_i       (Jump_i),
        .JumpAddr_i   (JumpAddr_i),
        .Instr_i      (Instr_i),
        .InstrAddr_o  (InstrAddr_o),
        .IFID_PC_o    (IFID_PC_o),
        .IFID_Instr_o (IFID_Instr_o),
        .IFID_Valid_o (IFID_Valid_o),
        .StallCnt_o   (StallCnt_o),
        .FlushCnt_o   (FlushCnt_o)
    );

    // Instruction memory: data is a fixed function of the address
    assign Instr_i = InstrAddr_o ^ 32'hA5A5_A5A5;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] ins, input logic v);
        check({tag, "_pc"}, IFID_PC_o, pc);
        check({tag, "_instr"}, IFID_Instr_o, ins);
        check({tag, "_valid"}, {31'h0, IFID_Valid_o}, {31'h0, v});
    endtask

    initial begin
        rst_n_i = 1'b0; start_i = 1'b0; PC_stall_i = 1'b0; IFID_stall_i = 1'b0;
        Branch_i = 1'b0; BranchAddr_i = 32'h0; Jump_i = 1'b0; JumpAddr_i = 32'h0;
        step();
        check("rst_addr", InstrAddr_o, 32'h0);
        check_ifid("rst", 32'h0, 32'h0, 1'b0);
        check("rst_stall", {16'h0, StallCnt_o}, 32'h0);
        check("rst_flush", {16'h0, FlushCnt_o}, 32'h0);
        rst_n_i = 1'b1; start_i = 1'b1;

        // Sequential fetch
        step();
        check("seq1_addr", InstrAddr_o, 32'h4);
        check_ifid("seq1", 32'h4, 32'hA5A5_A5A5, 1'b1);
        step();
        check("seq2_addr", InstrAddr_o, 32'h8);
        check_ifid("seq2", 32'h8, 32'hA5A5_A5A1, 1'b1);

        // Load-use stall for two cycles
        PC_stall_i = 1'b1; IFID_stall_i = 1'b1;
        step();
        check("lu1_addr", InstrAddr_o, 32'h8);
        check_ifid("lu1", 32'h8, 32'hA5A5_A5A1, 1'b1);
        step();
        check("lu2_addr", InstrAddr_o, 32'h8);
        check_ifid("lu2", 32'h8, 32'hA5A5_A5A1, 1'b1);
        check("lu2_stallcnt", {16'h0, StallCnt_o}, 32'd2);
        PC_stall_i = 1'b0; IFID_stall_i = 1'b0;
        step();
        check("res1_addr", InstrAddr_o, 32'hC);
        check_ifid("res1", 32'hC, 32'hA5A5_A5AD, 1'b1);
        step();
        check("res2_addr", InstrAddr_o, 32'h10);
        check_ifid("res2", 32'h10, 32'hA5A5_A5A9, 1'b1);

        // Taken branch at PC 0x10
        Branch_i = 1'b1; BranchAddr_i = 32'h40;
        step();
        check("br_addr", InstrAddr_o, 32'h40);
        check_ifid("br", 32'h0, 32'h0, 1'b0);
        check("br_flush", {16'h0, FlushCnt_o}, 32'd1);
        Branch_i = 1'b0;
        step();
        check("br_next_addr", InstrAddr_o, 32'h44);
        check_ifid("br_next", 32'h44, 32'hA5A5_A5E5, 1'b1);

        // Branch ignored while IF/ID is stalled
        Branch_i = 1'b1; BranchAddr_i = 32'h100; IFID_stall_i = 1'b1;
        step();
        check("brst_addr", InstrAddr_o, 32'h44);
        check("brst_flush", {16'h0, FlushCnt_o}, 32'd1);
        check("brst_stall", {16'h0, StallCnt_o}, 32'd3);
        check_ifid("brst", 32'h44, 32'hA5A5_A5E5, 1'b1);

        // Jump wins over branch
        IFID_stall_i = 1'b0; BranchAddr_i = 32'h40; Jump_i = 1'b1; JumpAddr_i = 32'h80;
        step();
        check("jb_addr", InstrAddr_o, 32'h80);
        check("jb_flush", {16'h0, FlushCnt_o}, 32'd2);

        // Target low bits forced to zero
        Branch_i = 1'b0; JumpAddr_i = 32'h83;
        step();
        check("jalign_addr", InstrAddr_o, 32'h80);
        check("jalign_flush", {16'h0, FlushCnt_o}, 32'd3);
        Jump_i = 1'b0;

        // PC stall alone: PC held, bubble into ID
        PC_stall_i = 1'b1;
        step();
        check("pcst_addr", InstrAddr_o, 32'h80);
        check_ifid("pcst", 32'h0, 32'h0, 1'b0);
        check("pcst_stall", {16'h0, StallCnt_o}, 32'd4);
        PC_stall_i = 1'b0;

        // start low: everything frozen, redirect ignored
        start_i = 1'b0; Branch_i = 1'b1; BranchAddr_i = 32'h200;
        step();
        check("stop_addr", InstrAddr_o, 32'h80);
        check_ifid("stop", 32'h0, 32'h0, 1'b0);
        check("stop_flush", {16'h0, FlushCnt_o}, 32'd3);
        check("stop_stall", {16'h0, StallCnt_o}, 32'd4);
        start_i = 1'b1; Branch_i = 1'b0;

        // PC wrap
        Jump_i = 1'b1; JumpAddr_i = 32'hFFFF_FFFF;
        step();
        check("wrapj_addr", InstrAddr_o, 32'hFFFF_FFFC);
        check("wrapj_flush", {16'h0, FlushCnt_o}, 32'd4);
        Jump_i = 1'b0;
        step();
        check("wrap_addr", InstrAddr_o, 32'h0);
        check_ifid("wrap", 32'h0, 32'h5A5A_5A59, 1'b1);

        // Stall counter saturation
        PC_stall_i = 1'b1;
        repeat (70000) step();
        check("sat_stall", {16'h0, StallCnt_o}, 32'h0000_FFFF);
        step();
        check("sat_hold", {16'h0, StallCnt_o}, 32'h0000_FFFF);
        check("sat_flush", {16'h0, FlushCnt_o}, 32'd4);

        // Asynchronous reset between clock edges
        #3;
        rst_n_i = 1'b0;
        #1;
        check("arst_addr", InstrAddr_o, 32'h0);
        check_ifid("arst", 32'h0, 32'h0, 1'b0);
        check("arst_stall", {16'h0, StallCnt_o}, 32'h0);
        check("arst_flush", {16'h0, FlushCnt_o}, 32'h0);
        PC_stall_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        step();
        check("post_addr", InstrAddr_o, 32'h4);
        check_ifid("post", 32'h4, 32'hA5A5_A5A5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
